uart_rx_byte: RTL and testbench

- UART receiver, 8N1, fixed baud set by parameter.
- Samples the asynchronous serial line and delivers each valid byte as `received_byte`, with a one-cycle `rx_done` pulse.
- Sits directly upstream of the decimal seven-segment display stage, which latches `received_byte` on `rx_done`.
- Also flags framing errors and exposes a busy indication for debug LEDs.

---
 rtl/uart_rx_byte.sv | 135 +++++++++++++
 tb/tb_uart_rx_byte.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with a fixed baud rate.
// The pin is synchronised, then the start, data and stop bits are each
// sampled once at mid-bit. Good frames update received_byte with a
// one-cycle rx_done pulse. A low stop bit gives a one-cycle frame_err
// pulse, and the receiver then waits in BREAK until the line idles high.
module uart_rx_byte #(
   parameter int unsigned CLKS_PER_BIT = 868,
   localparam int unsigned HALF_BIT    = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] received_byte,
   output logic       rx_done,
   output logic       frame_err,
   output logic       busy
);

   localparam logic [15:0] HALF_M1 = 16'(HALF_BIT - 1);
   localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t      state_q, state_d;
   logic        sync1_q, rx_s;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  byte_q, byte_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;

   // Next-state and output computation. The counter restarts on every
   // sample and on every state entry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d = S_DATA;
                  bit_d   = '0;
               end else begin
                  // A start bit that is high at mid-bit is a glitch. Drop it.
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_M1) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (cnt_q == BIT_M1) begin
               cnt_d = '0;
               if (rx_s) begin
                  byte_d  = shift_q;
                  done_d  = 1'b1;
                  // Leave half a bit early so a new start edge is not missed.
                  state_d = S_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            // Wait here so a held-low line is not decoded as repeated 0x00 frames.
            cnt_d = '0;
            if (rx_s) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // All state, including the two-flop input synchroniser. The synchroniser
   // resets high so that releasing reset does not look like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         rx_s    <= 1'b1;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync1_q <= rx;
         rx_s    <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign received_byte = byte_q;
   assign rx_done       = done_q;
   assign frame_err     = err_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte with CLKS_PER_BIT=16.
// The stimulus pushes the expected rx_done and frame_err events. Each event
// carries its byte and its exact cycle. A negedge monitor pops an event and
// compares it whenever the DUT pulses an output.
module tb_uart_rx_byte;

   localparam int CPB = 16;
   localparam int HB  = CPB / 2;
   localparam int LAT = HB + 9 * CPB + 3;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] received_byte;
   logic       rx_done, frame_err, busy;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   logic [7:0] last_good = 8'h00;

   uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx),
      .received_byte(received_byte), .rx_done(rx_done),
      .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every output pulse must match the next expected event.
   always @(negedge clk) begin
      if (rst_n && (rx_done || frame_err)) begin
         chk("done_err_exclusive", int'(rx_done && frame_err), 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pulse_kind", int'(frame_err), int'(e.is_err));
            chk("pulse_byte", int'(received_byte), int'(e.data));
            chk("pulse_cycle", cyc, e.cyc);
         end
      end
   end

   // Drive one frame from a negedge. Each bit lasts CPB cycles.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      exp_t e;
      e.is_err = !stop_bit;
      e.data   = stop_bit ? b : last_good;
      e.cyc    = cyc + LAT;
      exp_q.push_back(e);
      if (stop_bit) last_good = b;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
   endtask

   initial begin
      int bcnt;
      logic [7:0] v5a;
      // Reset, then an idle line.
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_byte", int'(received_byte), 8'h00);
      chk("idle_done", int'(rx_done), 0);

      // A single frame.
      send_frame(8'hA5, 1'b1);
      repeat (20) @(negedge clk);
      chk("a5_byte", int'(received_byte), 8'hA5);

      // Back-to-back frames with no idle gap.
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      repeat (20) @(negedge clk);
      chk("ff_byte", int'(received_byte), 8'hFF);

      // A short low glitch on the idle line.
      bcnt = 0;
      rx = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (i == 3) rx = 1'b1;
         @(negedge clk);
         if (busy) bcnt++;
      end
      chk("glitch_busy_short", int'(bcnt >= 1 && bcnt <= 9), 1);
      chk("glitch_busy_end", int'(busy), 0);

      // A frame with a low stop bit, then the line held low, then released.
      send_frame(8'h3C, 1'b0);
      repeat (100) @(negedge clk);
      chk("break_busy", int'(busy), 1);
      chk("break_byte", int'(received_byte), 8'hFF);
      rx = 1'b1;
      repeat (6) @(negedge clk);
      chk("break_release", int'(busy), 0);
      repeat (20) @(negedge clk);
      send_frame(8'h81, 1'b1);
      repeat (20) @(negedge clk);
      chk("81_byte", int'(received_byte), 8'h81);

      // Reset in the middle of the data bits.
      v5a = 8'h5A;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = v5a[i];
         repeat (CPB) @(negedge clk);
      end
      rst_n = 1'b0;
      rx = 1'b1;
      #1;
      chk("rst_byte", int'(received_byte), 8'h00);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(rx_done), 0);
      last_good = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      chk("post_rst_byte", int'(received_byte), 8'h00);
      send_frame(8'h12, 1'b1);
      repeat (20) @(negedge clk);
      chk("12_byte", int'(received_byte), 8'h12);

      chk("events_left", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
